// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, optional even parity, stop bit.
// Received words go out through a valid/ready port, with parity, framing and overrun status.
module serial_frame_rx #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             out_ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic             r_par;
  logic             r_mis;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_parity_err;
  logic             r_frame_err;
  logic             r_overrun;

  generate
    if (WIDTH == 1) begin : g_shift1
      assign w_shift_next = serial_in;
    end else begin : g_shiftn
      assign w_shift_next = {r_shift[WIDTH-2:0], serial_in};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (bit_en) begin
      case (r_state)
        S_IDLE:   if (!serial_in) w_next_state = S_DATA;
        S_DATA:   if (r_cnt == LAST_BIT) w_next_state = PARITY_EN ? S_PARITY : S_STOP;
        S_PARITY: w_next_state = S_STOP;
        S_STOP:   w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Delivery: a new word wins over acceptance on the same edge; overrun set wins over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_mis        <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (clear_err) r_overrun <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (bit_en) begin
        case (r_state)
          S_IDLE: begin
            if (!serial_in) begin
              r_cnt <= '0;
              r_par <= 1'b0;
            end
          end
          S_DATA: begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 1'b1;
            r_par   <= r_par ^ serial_in;
          end
          S_PARITY: r_mis <= r_par ^ serial_in;
          S_STOP: begin
            if (serial_in) begin
              r_out_data   <= r_shift;
              r_parity_err <= PARITY_EN ? r_mis : 1'b0;
              r_out_valid  <= 1'b1;
              if (r_out_valid && !out_ready) r_overrun <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (WIDTH=4, even parity): framing, handshake, errors, reset abort.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       bit_en;
  logic       out_ready;
  logic       clear_err;
  logic [3:0] out_data;
  logic       out_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int fails   = 0;

  serial_frame_rx #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_en     (bit_en),
    .out_ready  (out_ready),
    .clear_err  (clear_err),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap idle cycles (with serial_in toggling) precede each strobe
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      serial_in = ~serial_in;
      tick();
    end
    serial_in = b;
    bit_en    = 1'b1;
    tick();
    bit_en    = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic stp,
                            input logic rdy_at_stop, input int gap);
    send_bit(1'b0, gap);
    check1("busy_after_start", busy, 1'b1);
    check1("fe_after_start", frame_err, 1'b0);
    for (int i = 3; i >= 0; i--) send_bit(d[i], gap);
    send_bit(p, gap);
    out_ready = rdy_at_stop;
    send_bit(stp, gap);
    serial_in = 1'b1;
  endtask

  initial begin
    reset = 1'b1; serial_in = 1'b1; bit_en = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
    tick();
    tick();
    check4("rst_data", out_data, 4'b0000);
    check1("rst_valid", out_valid, 1'b0);
    check1("rst_perr", parity_err, 1'b0);
    check1("rst_ferr", frame_err, 1'b0);
    check1("rst_ovr", overrun, 1'b0);
    check1("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // basic frame 1011, parity 1
    out_ready = 1'b1;
    send_frame(4'b1011, 1'b1, 1'b1, 1'b1, 0);
    check4("basic_data", out_data, 4'b1011);
    check1("basic_valid", out_valid, 1'b1);
    check1("basic_perr", parity_err, 1'b0);
    check1("basic_busy", busy, 1'b0);
    tick();
    check1("basic_accept", out_valid, 1'b0);

    // parity error still delivers
    send_frame(4'b1011, 1'b0, 1'b1, 1'b1, 0);
    check4("perr_data", out_data, 4'b1011);
    check1("perr_valid", out_valid, 1'b1);
    check1("perr_flag", parity_err, 1'b1);
    tick();
    check1("perr_accept", out_valid, 1'b0);

    // framing error, then a good frame right away
    send_frame(4'b0110, 1'b0, 1'b0, 1'b1, 0);
    check1("ferr_pulse", frame_err, 1'b1);
    check1("ferr_valid", out_valid, 1'b0);
    check1("ferr_busy", busy, 1'b0);
    send_frame(4'b0011, 1'b0, 1'b1, 1'b1, 0);
    check4("after_ferr_data", out_data, 4'b0011);
    check1("after_ferr_valid", out_valid, 1'b1);
    check1("after_ferr_perr", parity_err, 1'b0);
    tick();

    // sparse strobes with toggling line between them
    send_frame(4'b1100, 1'b0, 1'b1, 1'b1, 3);
    check4("sparse_data", out_data, 4'b1100);
    check1("sparse_valid", out_valid, 1'b1);
    check1("sparse_perr", parity_err, 1'b0);
    tick();
    check1("sparse_accept", out_valid, 1'b0);

    // overrun, clear, and simultaneous completion/acceptance
    out_ready = 1'b0;
    send_frame(4'b0001, 1'b1, 1'b1, 1'b0, 0);
    check4("ovr1_data", out_data, 4'b0001);
    check1("ovr1_flag", overrun, 1'b0);
    send_frame(4'b1110, 1'b1, 1'b1, 1'b0, 0);
    check4("ovr2_data", out_data, 4'b1110);
    check1("ovr2_valid", out_valid, 1'b1);
    check1("ovr2_flag", overrun, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check1("ovr_clear", overrun, 1'b0);
    check1("ovr_valid_held", out_valid, 1'b1);
    send_frame(4'b0101, 1'b0, 1'b1, 1'b1, 0);
    check4("simul_data", out_data, 4'b0101);
    check1("simul_valid", out_valid, 1'b1);
    check1("simul_ovr", overrun, 1'b0);
    tick();
    check1("simul_accept", out_valid, 1'b0);

    // reset mid-frame
    out_ready = 1'b0;
    send_frame(4'b1010, 1'b0, 1'b1, 1'b0, 0);
    check1("pre_rst_valid", out_valid, 1'b1);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    check1("mid_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check4("midrst_data", out_data, 4'b0000);
    check1("midrst_valid", out_valid, 1'b0);
    check1("midrst_perr", parity_err, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    send_frame(4'b1001, 1'b0, 1'b1, 1'b1, 0);
    check4("post_rst_data", out_data, 4'b1001);
    check1("post_rst_valid", out_valid, 1'b1);
    check1("post_rst_perr", parity_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the 4-bit parallel-in/serial-out shift register. Takes its MSB-first serial output and reassembles framed words.
- Framing: start bit, WIDTH data bits, optional even-parity bit, stop bit.
- Delivers each word on a parallel port with a valid/ready handshake, plus parity/framing/overrun status.
- Sits between the transmit shift register and any parallel consumer, e.g. a display register or a second regPs-style stage.

Parameters:
- WIDTH, 4, data bits per frame; legal range 1..16.
- PARITY_EN, 1, when 1 an even-parity bit follows the data bits; when 0 the stop bit follows the data bits directly.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- serial_in  input  1  serial line, MSB first; idle level 1.
- bit_en  input  1  bit strobe; serial_in is sampled only on edges where bit_en=1.
- out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1.
- clear_err  input  1  clears the sticky overrun flag.
- out_data  output  WIDTH  last received word; bit [WIDTH-1] is the first data bit received.
- out_valid  output  1  out_data holds an unconsumed word.
- parity_err  output  1  parity check result for the word in out_data; 1 = mismatch.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled as 0.
- overrun  output  1  sticky; set when an unconsumed word is overwritten.
- busy  output  1  high while in any state other than IDLE.

Behaviour:
- Reset (synchronous, priority over all other inputs): state=IDLE, bit counter=0, shift register=0, out_data=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. Reset mid-frame aborts the frame; no partial word is ever delivered.
- FSM states: IDLE, DATA, PARITY, STOP. The FSM advances only on edges with bit_en=1. With bit_en=0 all state, the counter and the shift register hold.
- IDLE: a strobe with serial_in=0 is the start bit → DATA, counter=0. A strobe with serial_in=1 stays in IDLE.
- DATA:
  - Each strobe: shift <= {shift[WIDTH-2:0], serial_in} (for WIDTH=1, shift <= serial_in); counter++; running parity ^= serial_in.
  - After the WIDTH-th data bit → PARITY if PARITY_EN=1, else → STOP.
  - Counter width is $clog2(WIDTH+1).
- PARITY: the strobe samples the parity bit. Parity mismatch = running parity XOR sampled bit (even parity: data bits plus parity bit have an even number of ones). → STOP.
- STOP:
  - Strobe with serial_in=1: frame completes.
    - out_data <= shift; parity_err <= mismatch (0 if PARITY_EN=0); out_valid <= 1.
    - All three are visible the cycle after the stop-bit edge (latency: 1 clk from the stop-bit sample).
  - Strobe with serial_in=0: frame_err=1 for exactly one cycle. The word is discarded; out_data, out_valid and parity_err are unchanged. → IDLE. No break detection: a following strobe with 0 is treated as a new start bit.
  - In both cases → IDLE.
- Handshake: out_valid, once set, stays 1 until an edge with out_valid=1 and out_ready=1, which clears it. out_data is stable while out_valid=1, except when overwritten by a new word.
- Simultaneous completion and acceptance on the same edge: the new word loads, out_valid stays 1, no overrun.
- Completion with out_valid=1 and out_ready=0: the new word overwrites out_data and parity_err, and overrun <= 1.
- overrun clears on clear_err=1, unless an overrun occurs on the same edge; set wins.
- A parity error does not suppress delivery; out_valid still asserts.
- busy = (state != IDLE), registered state decode.
- The frame_err pulse lasts one clk regardless of bit_en spacing.

Test Plan:
- Basic frame, WIDTH=4, PARITY_EN=1, bit_en every cycle. Send 0,1,0,1,1,1,1 (start, data 1011, parity 1, stop), out_ready=1 → one cycle after the stop edge: out_data=4'b1011, out_valid=1, parity_err=0, busy=0. out_valid clears on the next edge.
- Parity error. Same frame with parity bit 0 → out_data=4'b1011, out_valid=1, parity_err=1.
- Framing error. Send data 4'b0110, parity 0, stop bit 0 → frame_err high for exactly 1 cycle; out_valid stays 0; FSM back in IDLE. A correct frame with data 4'b0011 follows immediately → out_data=4'b0011.
- Sparse strobes. bit_en=1 every 4th cycle, frame with data 4'b1100, with serial_in toggling on cycles where bit_en=0 → out_data=4'b1100. The toggles must be ignored.
- Overrun and clear. out_ready=0; receive 4'b0001, then 4'b1110 → out_data=4'b1110, overrun=1. Pulse clear_err → overrun=0 next cycle. Also check that completion and acceptance on the same edge give no overrun.
- Reset mid-frame. Assert reset after 2 data bits → all outputs 0, state IDLE. Next full frame with data 4'b1001 → out_data=4'b1001, with no leftover bits from the aborted frame.
